// File: rtl/audio_seq_ctl_pkg.sv
// Shared types and tables for the audio sequencer: FSM states, note dividers,
// volume amplitudes and the song ROM contents.
package audio_seq_ctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam logic [2:0] VOL_MAX = 3'd4;
    localparam logic [2:0] VOL_RST = 3'd2;

    // Half-period dividers at 100 MHz, index = note code (C4..C5); index 0 is rest.
    localparam logic [8:0][19:0] DIV_TABLE = {
        20'd95557,  20'd101239, 20'd113636, 20'd127551,
        20'd143172, 20'd151685, 20'd170265, 20'd191110,
        20'd0
    };

    localparam logic [4:0][15:0] AMP_TABLE = {
        16'h4000, 16'h2000, 16'h1000, 16'h0800, 16'h0000
    };

    // Entry 0 is the rightmost nibble.
    localparam logic [15:0][3:0] SONG_ROM = {
        4'd5, 4'd3, 4'd1, 4'd0,
        4'd1, 4'd2, 4'd3, 4'd4,
        4'd5, 4'd6, 4'd5, 4'd5,
        4'd3, 4'd8, 4'd0, 4'd1
    };

    function automatic logic [19:0] div_of(input logic [3:0] code);
        logic [19:0] d;
        d = '0;
        if (code >= 4'd1 && code <= 4'd8) begin
            d = DIV_TABLE[code];
        end
        return d;
    endfunction

    function automatic logic [15:0] amp_of(input logic [2:0] v);
        logic [15:0] a;
        a = '0;
        if (v <= VOL_MAX) begin
            a = AMP_TABLE[v];
        end
        return a;
    endfunction

endpackage

// File: rtl/audio_seq_ctl_note_rom.sv
// Combinational song ROM: maps a song position to a 4-bit note code.
module note_rom
    import audio_seq_ctl_pkg::*;
(
    input  logic [3:0] addr,
    output logic [3:0] code
);

    assign code = SONG_ROM[addr];

endmodule

// File: rtl/audio_seq_ctl.sv
// Song sequencer: steps through the note ROM producing a square-wave sample
// stream with beat/gap timing, volume control and mute.
module audio_seq_ctl
    import audio_seq_ctl_pkg::*;
#(
    parameter int unsigned BEAT_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES  = 2_500_000,
    parameter int unsigned SONG_LEN    = 16
) (
    input  logic        clk_100mhz,
    input  logic        rst_n,
    input  logic        play,
    input  logic        stop,
    input  logic        vol_up,
    input  logic        vol_dn,
    input  logic        mute,
    input  logic        loop_en,
    output logic [15:0] audio_left,
    output logic [15:0] audio_right,
    output logic [3:0]  note_idx,
    output logic [2:0]  vol,
    output logic        busy
);

    localparam int unsigned MAX_CYC = (BEAT_CYCLES > GAP_CYCLES) ? BEAT_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [3:0]       LAST_IDX  = 4'(SONG_LEN - 1);

    state_e           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [19:0]      hp_q, hp_d;
    logic             ph_q, ph_d;
    logic [2:0]       vol_q, vol_d;
    logic [15:0]      audio_q, audio_d;
    logic             busy_q, busy_d;
    logic             note_start;
    logic [3:0]       code;
    logic [19:0]      div;
    logic [15:0]      amp;

    // ROM is addressed by the next position so outputs line up with the state register.
    note_rom u_note_rom (
        .addr (idx_d),
        .code (code)
    );

    assign div = div_of(code);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        note_start = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (play) begin
                        state_d    = ST_PLAY;
                        idx_d      = '0;
                        cnt_d      = '0;
                        note_start = 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (cnt_q == BEAT_LAST) begin
                        state_d = ST_GAP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d = '0;
                        if (idx_q != LAST_IDX) begin
                            state_d    = ST_PLAY;
                            idx_d      = idx_q + 4'd1;
                            note_start = 1'b1;
                        end else if (loop_en) begin
                            state_d    = ST_PLAY;
                            idx_d      = '0;
                            note_start = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        vol_d = vol_q;
        if (vol_up && !vol_dn && vol_q < VOL_MAX) begin
            vol_d = vol_q + 3'd1;
        end else if (vol_dn && !vol_up && vol_q != 3'd0) begin
            vol_d = vol_q - 3'd1;
        end

        hp_d = hp_q;
        ph_d = ph_q;
        if (note_start) begin
            hp_d = '0;
            ph_d = 1'b1;
        end else if (state_d == ST_PLAY) begin
            if (div != '0) begin
                if (hp_q == div - 20'd1) begin
                    hp_d = '0;
                    ph_d = ~ph_q;
                end else begin
                    hp_d = hp_q + 20'd1;
                end
            end
        end else begin
            hp_d = '0;
            ph_d = 1'b0;
        end

        amp     = amp_of(vol_d);
        audio_d = '0;
        if (state_d == ST_PLAY && !mute && div != '0) begin
            audio_d = ph_d ? amp : (~amp + 16'd1);
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            hp_q    <= '0;
            ph_q    <= 1'b0;
            vol_q   <= VOL_RST;
            audio_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            hp_q    <= hp_d;
            ph_q    <= ph_d;
            vol_q   <= vol_d;
            audio_q <= audio_d;
            busy_q  <= busy_d;
        end
    end

    assign audio_left  = audio_q;
    assign audio_right = audio_q;
    assign note_idx    = idx_q;
    assign vol         = vol_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_audio_seq_ctl.sv
// Bench for audio_seq_ctl with a short song: timeline model checked every cycle
// plus hand-computed spot checks.
module tb_audio_seq_ctl;

    localparam int BEAT = 8;
    localparam int GAP  = 2;
    localparam int SLEN = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        play = 1'b0, stop = 1'b0, vol_up = 1'b0, vol_dn = 1'b0;
    logic        mute = 1'b0, loop_en = 1'b0;
    logic [15:0] audio_left, audio_right;
    logic [3:0]  note_idx;
    logic [2:0]  vol;
    logic        busy;

    int total  = 0;
    int passed = 0;

    audio_seq_ctl #(
        .BEAT_CYCLES (BEAT),
        .GAP_CYCLES  (GAP),
        .SONG_LEN    (SLEN)
    ) dut (
        .clk_100mhz  (clk),
        .rst_n       (rst_n),
        .play        (play),
        .stop        (stop),
        .vol_up      (vol_up),
        .vol_dn      (vol_dn),
        .mute        (mute),
        .loop_en     (loop_en),
        .audio_left  (audio_left),
        .audio_right (audio_right),
        .note_idx    (note_idx),
        .vol         (vol),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Model: one tick counter over the whole note period (beat followed by gap).
    int          rom  [4] = '{1, 0, 8, 3};
    int          divs [9] = '{0, 191110, 170265, 151685, 143172, 127551, 113636, 101239, 95557};
    logic [15:0] amps [5] = '{16'h0000, 16'h0800, 16'h1000, 16'h2000, 16'h4000};
    int   m_idx  = 0;
    int   m_tick = 0;
    int   m_vol  = 2;
    logic m_busy = 1'b0;
    logic m_mute = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        int t, i, v;
        logic b;
        if (!rst_n) begin
            m_idx  <= 0;
            m_tick <= 0;
            m_vol  <= 2;
            m_busy <= 1'b0;
            m_mute <= 1'b0;
        end else begin
            t = m_tick;
            i = m_idx;
            v = m_vol;
            b = m_busy;
            if (vol_up && !vol_dn && v < 4) v = v + 1;
            else if (vol_dn && !vol_up && v > 0) v = v - 1;
            if (stop) begin
                b = 1'b0;
            end else if (!b) begin
                if (play) begin
                    b = 1'b1;
                    i = 0;
                    t = 0;
                end
            end else begin
                t = t + 1;
                if (t == BEAT + GAP) begin
                    t = 0;
                    if (i < SLEN - 1) i = i + 1;
                    else if (loop_en) i = 0;
                    else b = 1'b0;
                end
            end
            m_tick <= t;
            m_idx  <= i;
            m_vol  <= v;
            m_busy <= b;
            m_mute <= mute;
        end
    end

    function automatic logic [15:0] exp_audio();
        int          c;
        logic [15:0] a;
        if (!m_busy || m_tick >= BEAT || m_mute) return 16'h0000;
        c = rom[m_idx];
        if (c == 0 || c > 8) return 16'h0000;
        a = amps[m_vol];
        return (((m_tick / divs[c]) % 2) == 0) ? a : (16'h0000 - a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act === exp) passed = passed + 1;
        else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    endtask

    always @(negedge clk) begin
        chk("audio_left",  32'(audio_left),  32'(exp_audio()));
        chk("audio_right", 32'(audio_right), 32'(exp_audio()));
        chk("note_idx",    32'(note_idx),    32'(m_idx));
        chk("vol",         32'(vol),         32'(m_vol));
        chk("busy",        32'(busy),        32'(m_busy));
    end

    task automatic drive(input logic p, input logic s, input logic u, input logic d);
        @(posedge clk);
        #1;
        play = p; stop = s; vol_up = u; vol_dn = d;
        @(posedge clk);
        #1;
        play = 1'b0; stop = 1'b0; vol_up = 1'b0; vol_dn = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vol",  32'(vol), 32'd2);
        chk("rst_audio", 32'(audio_left), 32'h0);
        rst_n = 1'b1;

        // Full song, no loop
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("start_busy",  32'(busy), 32'd1);
        chk("start_audio", 32'(audio_left), 32'h1000);
        repeat (7) @(negedge clk);
        chk("beat_last", 32'(audio_left), 32'h1000);
        @(negedge clk);
        chk("gap_audio", 32'(audio_left), 32'h0);
        chk("gap_busy",  32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        chk("rest_idx",   32'(note_idx), 32'd1);
        chk("rest_audio", 32'(audio_left), 32'h0);
        repeat (10) @(negedge clk);
        chk("n2_idx",   32'(note_idx), 32'd2);
        chk("n2_audio", 32'(audio_left), 32'h1000);
        repeat (19) @(negedge clk);
        chk("last_gap_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("end_busy", 32'(busy), 32'd0);

        // Looping, ignored play, play+stop collision
        loop_en = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (41) @(negedge clk);
        chk("wrap_idx",   32'(note_idx), 32'd0);
        chk("wrap_audio", 32'(audio_left), 32'h1000);
        repeat (20) @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("play_ignored", 32'(note_idx), 32'd2);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("stop_wins_busy",  32'(busy), 32'd0);
        chk("stop_wins_audio", 32'(audio_left), 32'h0);
        loop_en = 1'b0;

        // Volume saturation
        for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("vol_hi", 32'(vol), 32'd4);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("amp_max", 32'(audio_left), 32'h4000);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) drive(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("vol_lo", 32'(vol), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("vol0_busy",  32'(busy), 32'd1);
        chk("vol0_audio", 32'(audio_left), 32'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("vol_updn", 32'(vol), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        // Mute during note 2 at vol 3, then reset in the following gap
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (22) @(negedge clk);
        mute = 1'b1;
        @(negedge clk);
        chk("mute_audio", 32'(audio_left), 32'h0);
        chk("mute_idx",   32'(note_idx), 32'd2);
        repeat (3) @(negedge clk);
        mute = 1'b0;
        @(negedge clk);
        chk("unmute_audio", 32'(audio_left), 32'h2000);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_audio", 32'(audio_left), 32'h0);
        chk("arst_busy",  32'(busy), 32'd0);
        chk("arst_vol",   32'(vol), 32'd2);
        chk("arst_idx",   32'(note_idx), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("needs_play", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
